req_fork_ctrl: RTL and testbench
================================

Name: req_fork_ctrl

Overview:
Clocked, parametrised successor to the per-port request generator in the Ipm.
- Accepts a 2-phase (transition-signalled) request from an upstream stage.
- Forks it to a per-packet subset of NUM_OUT downstream ports, joins their 2-phase acks, then acknowledges upstream.
- Tracks packet enable from head to tail and adds stall detection, protocol-error flagging and flit counting.
- Sits between the input buffer and the output ports of a router.

Parameters:
NUM_OUT, 4, number of downstream ports (>=1)
SYNC_STAGES, 2, flops in each input toggle synchroniser (0 = inputs already synchronous)
TIMEOUT, 256, cycles in WAIT before stall_o asserts (0 disables)
CNT_W, 8, width of flit counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_up_i  in  1  upstream 2-phase request (each toggle = one flit)
ack_up_o  out  1  upstream 2-phase ack
head_i  in  1  flit is head; bundled with req_up_i
tail_i  in  1  flit is tail; bundled with req_up_i
route_i  in  NUM_OUT  destination mask, valid with head flit
req_dw_o  out  NUM_OUT  per-port 2-phase requests
ack_dw_i  in  NUM_OUT  per-port 2-phase acks
pkt_active_o  out  1  packet enable: high from accepted head until tail acked
route_o  out  NUM_OUT  latched route of current packet
stall_o  out  1  WAIT exceeded TIMEOUT cycles
err_o  out  1  one-cycle pulse on protocol error
flit_cnt_o  out  CNT_W  flits accepted in current packet, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; req_seen, ack_seen, pending, timers 0. Reset mid-operation abandons the flit; neighbours must be reset together.
- Synchronisation:
  - req_up_i and each ack_dw_i bit pass through SYNC_STAGES flops -> req_s, ack_s.
  - Edges: req_ev = req_s ^ req_seen; ack_ev[k] = ack_s[k] ^ ack_seen[k].
  - head_i/tail_i/route_i are sampled in the cycle req_ev is seen. The bundling delay is the sender's responsibility.
- States: IDLE, PKT, WAIT.
- IDLE, req_ev:
  - head_i=1 and route_i!=0: latch route_o=route_i, pkt_active_o=1, flit_cnt_o=1, latch tail flag, toggle req_dw_o on route bits, pending=route_i, req_seen toggles, go to WAIT.
  - head_i=0 or route_i==0: err_o pulse, flit dropped. ack_up_o and req_seen toggle the same cycle. Stay in IDLE.
- PKT, req_ev:
  - Toggle req_dw_o on route_o bits, pending=route_o, flit_cnt_o+1 (saturating at 2^CNT_W-1), latch tail flag, go to WAIT.
  - head_i=1 here: err_o pulse; the flit is forwarded as a body flit and the route is not relatched.
- WAIT:
  - Each ack_ev[k] with pending[k]=1 clears pending[k] and toggles ack_seen[k].
  - ack_ev[k] with pending[k]=0: err_o pulse, ack_seen[k] toggles, otherwise ignored.
  - Simultaneous acks on several ports are all consumed in one cycle.
  - When pending becomes 0 (registered, evaluated the next cycle): toggle ack_up_o. If tail flag is set -> IDLE with pkt_active_o=0 (route_o and flit_cnt_o hold until the next head); else -> PKT.
  - A single-flit packet (head=tail=1) returns to IDLE after one join.
  - req_ev during WAIT is not consumed until the state leaves WAIT (req_seen unchanged).
- Latency (SYNC_STAGES=0): req toggle -> req_dw_o toggle 1 cycle; last ack toggle -> ack_up_o toggle 2 cycles.
- Timeout:
  - Counter runs only in WAIT and clears on exit.
  - stall_o=1 once the counter reaches TIMEOUT; it stays high until WAIT exits.
  - Counter saturates, no wrap.
- err_o pulses are the OR of all error conditions in a cycle; they never block progress.

Decomposition:
- Package req_fork_pkg: state enum (IDLE, PKT, WAIT), default parameter constants, error-cause encoding.
- Sub-module toggle_sync (parametrised width and stage count; passthrough when stages=0). Instantiated once for req and once for the ack vector.

Test Plan:
1. NUM_OUT=4, SYNC_STAGES=0. Head flit with route=4'b0101, then body, then tail; acks from ports 0 and 2 each flit -> req_dw_o bits 0 and 2 toggle 3 times, bits 1 and 3 never toggle. ack_up_o toggles 3 times. pkt_active_o falls after the 3rd join. flit_cnt_o=3.
2. Single-flit packet, head=tail=1, route=4'b1000; ack port 3 -> ack_up_o toggles 2 cycles after the ack; state is IDLE and pkt_active_o=0 the cycle after.
3. Body flit (head=0) while IDLE -> err_o pulses once, ack_up_o toggles, req_dw_o unchanged. Same response for head with route=0.
4. Route=4'b0011; ack port 0 at cycle 5, port 1 at cycle 20; spurious ack on port 2 -> err_o pulse; ack_up_o toggles only after the port 1 ack.
5. TIMEOUT=16, route=4'b0001, ack withheld -> stall_o rises 16 cycles into WAIT. Then ack -> stall_o clears on WAIT exit.
6. Assert rst_ni low mid-WAIT -> all outputs 0 immediately (asynchronous). After release, a new head is accepted normally.

Source files
------------

// File: rtl/req_fork_pkg.sv
// Shared types and defaults for the 2-phase request fork/join controller.
package req_fork_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int DEF_NUM_OUT     = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 256;
    localparam int DEF_CNT_W       = 8;

    // Bit positions in the per-cycle error-cause vector.
    typedef enum logic [1:0] {
        ERR_NO_HEAD     = 2'd0,
        ERR_NULL_ROUTE  = 2'd1,
        ERR_HEAD_IN_PKT = 2'd2,
        ERR_SPUR_ACK    = 2'd3
    } err_cause_e;

    localparam int ERR_W = 4;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for transition-signalled lines; STAGES=0 is a plain wire.
module toggle_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
        end else begin : g_sync
            logic [WIDTH-1:0] chain [STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) chain[i] <= '0;
                end else begin
                    chain[0] <= din;
                    for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
                end
            end

            assign dout = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/req_fork_ctrl.sv
// Forks a 2-phase upstream request to the packet's route ports and joins their
// acks; tracks packet extent, stalls, protocol errors and flit count.
module req_fork_ctrl
    import req_fork_pkg::*;
#(
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_up_i,
    output logic               ack_up_o,
    input  logic               head_i,
    input  logic               tail_i,
    input  logic [NUM_OUT-1:0] route_i,
    output logic [NUM_OUT-1:0] req_dw_o,
    input  logic [NUM_OUT-1:0] ack_dw_i,
    output logic               pkt_active_o,
    output logic [NUM_OUT-1:0] route_o,
    output logic               stall_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   flit_cnt_o
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_e             state;
    logic               req_s;
    logic               req_seen;
    logic               req_ev;
    logic               tail_q;
    logic [NUM_OUT-1:0] ack_s;
    logic [NUM_OUT-1:0] ack_seen;
    logic [NUM_OUT-1:0] ack_ev;
    logic [NUM_OUT-1:0] pending;
    logic [TMR_W-1:0]   tmr;
    logic [ERR_W-1:0]   err_cause;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    toggle_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (req_up_i),
        .dout  (req_s)
    );

    toggle_sync #(.WIDTH(NUM_OUT), .STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (ack_dw_i),
        .dout  (ack_s)
    );

    assign req_ev = req_s ^ req_seen;
    assign ack_ev = ack_s ^ ack_seen;

    // Any ack on a port not awaiting one is spurious, whatever the state.
    always_comb begin
        err_cause = '0;
        if (|(ack_ev & ~pending)) err_cause[ERR_SPUR_ACK] = 1'b1;
        if (state == IDLE && req_ev) begin
            if (!head_i)            err_cause[ERR_NO_HEAD]    = 1'b1;
            else if (route_i == '0) err_cause[ERR_NULL_ROUTE] = 1'b1;
        end
        if (state == PKT && req_ev && head_i) err_cause[ERR_HEAD_IN_PKT] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            req_seen     <= 1'b0;
            ack_seen     <= '0;
            pending      <= '0;
            tail_q       <= 1'b0;
            tmr          <= '0;
            ack_up_o     <= 1'b0;
            req_dw_o     <= '0;
            pkt_active_o <= 1'b0;
            route_o      <= '0;
            stall_o      <= 1'b0;
            err_o        <= 1'b0;
            flit_cnt_o   <= '0;
        end else begin
            err_o    <= |err_cause;
            ack_seen <= ack_s;
            pending  <= pending & ~ack_ev;

            case (state)
                IDLE: begin
                    if (req_ev) begin
                        req_seen <= ~req_seen;
                        if (head_i && (route_i != '0)) begin
                            route_o      <= route_i;
                            pkt_active_o <= 1'b1;
                            flit_cnt_o   <= CNT_W'(1);
                            tail_q       <= tail_i;
                            req_dw_o     <= req_dw_o ^ route_i;
                            pending      <= route_i;
                            state        <= WAIT;
                        end else begin
                            ack_up_o <= ~ack_up_o;
                        end
                    end
                end

                PKT: begin
                    if (req_ev) begin
                        req_seen   <= ~req_seen;
                        req_dw_o   <= req_dw_o ^ route_o;
                        pending    <= route_o;
                        flit_cnt_o <= sat_inc(flit_cnt_o);
                        tail_q     <= tail_i;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    // Join completes on the registered pending mask, one cycle after the last ack.
                    if (pending == '0) begin
                        ack_up_o <= ~ack_up_o;
                        tmr      <= '0;
                        stall_o  <= 1'b0;
                        if (tail_q) begin
                            state        <= IDLE;
                            pkt_active_o <= 1'b0;
                        end else begin
                            state <= PKT;
                        end
                    end else if (TIMEOUT > 0) begin
                        if (tmr != TMR_MAX) tmr <= tmr + 1'b1;
                        if (tmr >= TMR_MAX - 1'b1) stall_o <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_fork_ctrl.sv
// Randomised and directed bench for req_fork_ctrl against a flit-level reference model.
module tb_req_fork_ctrl;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int TO = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req, head, tail;
    logic [N-1:0]  route, ack_dw;
    logic          ack_up, pkt_active, stall, err;
    logic [N-1:0]  req_dw, route_q;
    logic [CW-1:0] flit_cnt;

    logic          s_rst_n, s_req, s_head, s_tail;
    logic [N-1:0]  s_route, s_ack_dw;
    logic          s_ack_up, s_pkt_active, s_stall, s_err;
    logic [N-1:0]  s_req_dw, s_route_q;
    logic [7:0]    s_flit_cnt;

    req_fork_ctrl #(.NUM_OUT(N), .SYNC_STAGES(0), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_up_i(req), .ack_up_o(ack_up),
        .head_i(head), .tail_i(tail), .route_i(route), .req_dw_o(req_dw),
        .ack_dw_i(ack_dw), .pkt_active_o(pkt_active), .route_o(route_q),
        .stall_o(stall), .err_o(err), .flit_cnt_o(flit_cnt)
    );

    req_fork_ctrl #(.NUM_OUT(N), .SYNC_STAGES(2), .TIMEOUT(256), .CNT_W(8)) dut_sync (
        .clk_i(clk), .rst_ni(s_rst_n), .req_up_i(s_req), .ack_up_o(s_ack_up),
        .head_i(s_head), .tail_i(s_tail), .route_i(s_route), .req_dw_o(s_req_dw),
        .ack_dw_i(s_ack_dw), .pkt_active_o(s_pkt_active), .route_o(s_route_q),
        .stall_o(s_stall), .err_o(s_err), .flit_cnt_o(s_flit_cnt)
    );

    int checks = 0;
    int passed = 0;
    int err_pulses = 0;

    // Reference model: expected downstream request levels and upstream ack level.
    logic [N-1:0] m_req_dw;
    logic         m_ack_up;

    always @(negedge clk) if (err === 1'b1) err_pulses++;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic h, input logic t, input logic [N-1:0] r);
        head = h; tail = t; route = r; req = ~req;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_rst_n = 1'b0;
        req = 0; head = 0; tail = 0; route = '0; ack_dw = '0;
        s_req = 0; s_head = 0; s_tail = 0; s_route = '0; s_ack_dw = '0;
        m_req_dw = '0; m_ack_up = 1'b0;
        tick(3);
        checks++; if ({ack_up, req_dw, pkt_active, route_q, stall, err, flit_cnt} !== '0)
            $display("FAIL reset outputs: got %b expected all zero", {ack_up, req_dw, pkt_active, route_q, stall, err, flit_cnt});
        else passed++;
        #2; rst_n = 1'b1; s_rst_n = 1'b1;
        tick(2);
        checks++; if ({ack_up, req_dw, pkt_active} !== '0)
            $display("FAIL reset idle after release: got %b expected 0", {ack_up, req_dw, pkt_active});
        else passed++;
    endtask

    task automatic test_multi_flit;
        for (int i = 0; i < 3; i++) begin
            send(i == 0, i == 2, 4'b0101);
            tick();
            m_req_dw ^= 4'b0101;
            checks++; if (req_dw !== m_req_dw)
                $display("FAIL multi req_dw flit %0d: got %b expected %b", i, req_dw, m_req_dw);
            else passed++;
            ack_dw ^= 4'b0101;
            tick();
            checks++; if (ack_up !== m_ack_up)
                $display("FAIL multi ack_up early flit %0d: got %b expected %b", i, ack_up, m_ack_up);
            else passed++;
            tick();
            m_ack_up = ~m_ack_up;
            checks++; if (ack_up !== m_ack_up)
                $display("FAIL multi ack_up flit %0d: got %b expected %b", i, ack_up, m_ack_up);
            else passed++;
        end
        checks++; if ({pkt_active, flit_cnt, route_q} !== {1'b0, 3'd3, 4'b0101})
            $display("FAIL multi end pkt/cnt/route: got %b %0d %b expected 0 3 0101", pkt_active, flit_cnt, route_q);
        else passed++;
    endtask

    task automatic test_single_flit;
        send(1'b1, 1'b1, 4'b1000);
        tick();
        m_req_dw ^= 4'b1000;
        checks++; if (req_dw !== m_req_dw || pkt_active !== 1'b1)
            $display("FAIL single req_dw/pkt: got %b %b expected %b 1", req_dw, pkt_active, m_req_dw);
        else passed++;
        ack_dw ^= 4'b1000;
        tick();
        checks++; if (ack_up !== m_ack_up)
            $display("FAIL single ack_up early: got %b expected %b", ack_up, m_ack_up);
        else passed++;
        tick();
        m_ack_up = ~m_ack_up;
        checks++; if (ack_up !== m_ack_up || pkt_active !== 1'b0 || flit_cnt !== CW'(1))
            $display("FAIL single join: got ack %b pkt %b cnt %0d expected %b 0 1", ack_up, pkt_active, flit_cnt, m_ack_up);
        else passed++;
    endtask

    task automatic test_idle_errors;
        logic [N-1:0] rt [2];
        logic         hd [2];
        rt[0] = 4'b0110; hd[0] = 1'b0;
        rt[1] = 4'b0000; hd[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(hd[i], 1'b0, rt[i]);
            tick();
            m_ack_up = ~m_ack_up;
            checks++; if (err !== 1'b1 || ack_up !== m_ack_up || req_dw !== m_req_dw || pkt_active !== 1'b0)
                $display("FAIL idle drop %0d: got err %b ack %b req_dw %b pkt %b expected 1 %b %b 0",
                         i, err, ack_up, req_dw, pkt_active, m_ack_up, m_req_dw);
            else passed++;
            tick();
            checks++; if (err !== 1'b0)
                $display("FAIL idle drop %0d pulse width: got err %b expected 0", i, err);
            else passed++;
        end
    endtask

    task automatic test_head_in_pkt;
        send(1'b1, 1'b0, 4'b0001);
        tick(); m_req_dw ^= 4'b0001;
        ack_dw ^= 4'b0001; tick(2); m_ack_up = ~m_ack_up;
        send(1'b1, 1'b0, 4'b0010);
        tick(); m_req_dw ^= 4'b0001;
        checks++; if (err !== 1'b1 || req_dw !== m_req_dw || route_q !== 4'b0001)
            $display("FAIL head in pkt: got err %b req_dw %b route %b expected 1 %b 0001", err, req_dw, route_q, m_req_dw);
        else passed++;
        ack_dw ^= 4'b0001; tick(2); m_ack_up = ~m_ack_up;
        send(1'b0, 1'b1, 4'b0000);
        tick(); m_req_dw ^= 4'b0001;
        ack_dw ^= 4'b0001; tick(2); m_ack_up = ~m_ack_up;
        checks++; if (ack_up !== m_ack_up || pkt_active !== 1'b0 || flit_cnt !== CW'(3) || req_dw !== m_req_dw)
            $display("FAIL head in pkt end: got ack %b pkt %b cnt %0d req_dw %b expected %b 0 3 %b",
                     ack_up, pkt_active, flit_cnt, req_dw, m_ack_up, m_req_dw);
        else passed++;
    endtask

    task automatic test_partial_join;
        send(1'b1, 1'b1, 4'b0011);
        tick(); m_req_dw ^= 4'b0011;
        tick(4);
        ack_dw ^= 4'b0001;
        tick(3);
        ack_dw ^= 4'b0100;
        tick();
        checks++; if (err !== 1'b1)
            $display("FAIL partial spurious ack err: got %b expected 1", err);
        else passed++;
        tick(11);
        checks++; if (ack_up !== m_ack_up || pkt_active !== 1'b1)
            $display("FAIL partial held: got ack %b pkt %b expected %b 1", ack_up, pkt_active, m_ack_up);
        else passed++;
        ack_dw ^= 4'b0010;
        tick();
        checks++; if (ack_up !== m_ack_up)
            $display("FAIL partial ack_up early: got %b expected %b", ack_up, m_ack_up);
        else passed++;
        tick(); m_ack_up = ~m_ack_up;
        checks++; if (ack_up !== m_ack_up || pkt_active !== 1'b0 || stall !== 1'b0)
            $display("FAIL partial join: got ack %b pkt %b stall %b expected %b 0 0", ack_up, pkt_active, stall, m_ack_up);
        else passed++;
    endtask

    task automatic test_timeout;
        send(1'b1, 1'b1, 4'b0001);
        tick(); m_req_dw ^= 4'b0001;
        tick(TO - 1);
        checks++; if (stall !== 1'b0)
            $display("FAIL timeout early: got stall %b expected 0 at %0d cycles", stall, TO - 1);
        else passed++;
        tick();
        checks++; if (stall !== 1'b1)
            $display("FAIL timeout rise: got stall %b expected 1 at %0d cycles", stall, TO);
        else passed++;
        tick(10);
        checks++; if (stall !== 1'b1)
            $display("FAIL timeout hold: got stall %b expected 1", stall);
        else passed++;
        ack_dw ^= 4'b0001;
        tick(2); m_ack_up = ~m_ack_up;
        checks++; if (stall !== 1'b0 || ack_up !== m_ack_up)
            $display("FAIL timeout clear: got stall %b ack %b expected 0 %b", stall, ack_up, m_ack_up);
        else passed++;
    endtask

    task automatic test_random;
        int exp_err, err_start, len, errs_bad, sp;
        logic [N-1:0] rt, masks[$];
        logic h, t;
        exp_err = 0; errs_bad = 0;
        err_start = err_pulses;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                send(1'b0, 1'b0, N'($urandom_range(0, 15)));
                tick(); m_ack_up = ~m_ack_up; exp_err++;
                checks++; if (ack_up !== m_ack_up || req_dw !== m_req_dw)
                    $display("FAIL rand drop pkt %0d: got ack %b req_dw %b expected %b %b", p, ack_up, req_dw, m_ack_up, m_req_dw);
                else passed++;
            end
            rt = N'($urandom_range(1, 15));
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                h = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                if (k > 0 && h) exp_err++;
                t = (k == len - 1);
                send(h, t, (k == 0) ? rt : N'($urandom_range(0, 15)));
                tick(); m_req_dw ^= rt;
                checks++; if (req_dw !== m_req_dw)
                    $display("FAIL rand req_dw pkt %0d flit %0d: got %b expected %b", p, k, req_dw, m_req_dw);
                else passed++;
                masks.delete();
                for (int b = 0; b < N; b++) if (rt[b]) masks.push_back(N'(1) << b);
                for (int i = masks.size() - 1; i > 0; i--) begin
                    int j; logic [N-1:0] tmp;
                    j = $urandom_range(0, i);
                    tmp = masks[i]; masks[i] = masks[j]; masks[j] = tmp;
                end
                if (rt != 4'hF && $urandom_range(0, 3) == 0) begin
                    sp = $urandom_range(0, N - 1);
                    while (rt[sp]) sp = (sp + 1) % N;
                    masks.insert($urandom_range(0, masks.size() - 1), N'(1) << sp);
                    exp_err++;
                end
                for (int i = 0; i < masks.size(); i++) begin
                    ack_dw ^= masks[i];
                    if (i < masks.size() - 1) tick($urandom_range(1, 3));
                end
                tick();
                checks++; if (ack_up !== m_ack_up)
                    $display("FAIL rand ack_up early pkt %0d flit %0d: got %b expected %b", p, k, ack_up, m_ack_up);
                else passed++;
                tick(); m_ack_up = ~m_ack_up;
                checks++; if (ack_up !== m_ack_up || pkt_active !== !t || route_q !== rt
                              || flit_cnt !== ((k + 1 > int'(CNT_MAX)) ? CNT_MAX : CW'(k + 1)))
                    $display("FAIL rand join pkt %0d flit %0d: got ack %b pkt %b route %b cnt %0d expected %b %b %b %0d",
                             p, k, ack_up, pkt_active, route_q, flit_cnt, m_ack_up, !t, rt,
                             (k + 1 > int'(CNT_MAX)) ? int'(CNT_MAX) : k + 1);
                else passed++;
            end
        end
        tick(2);
        checks++; if (err_pulses - err_start !== exp_err)
            $display("FAIL rand err count: got %0d expected %0d", err_pulses - err_start, exp_err);
        else passed++;
    endtask

    task automatic test_async_reset;
        send(1'b1, 1'b0, 4'b0010);
        tick(3);
        #2; rst_n = 1'b0;
        #1;
        checks++; if ({ack_up, req_dw, pkt_active, route_q, stall, err, flit_cnt} !== '0)
            $display("FAIL async reset: got %b expected all zero", {ack_up, req_dw, pkt_active, route_q, stall, err, flit_cnt});
        else passed++;
        req = 0; head = 0; tail = 0; route = '0; ack_dw = '0;
        m_req_dw = '0; m_ack_up = 1'b0;
        tick(2);
        #2; rst_n = 1'b1;
        tick(2);
        send(1'b1, 1'b1, 4'b0100);
        tick(); m_req_dw ^= 4'b0100;
        checks++; if (req_dw !== m_req_dw || pkt_active !== 1'b1 || route_q !== 4'b0100 || flit_cnt !== CW'(1))
            $display("FAIL post reset head: got req_dw %b pkt %b route %b cnt %0d expected %b 1 0100 1",
                     req_dw, pkt_active, route_q, flit_cnt, m_req_dw);
        else passed++;
        ack_dw ^= 4'b0100;
        tick(2); m_ack_up = ~m_ack_up;
        checks++; if (ack_up !== m_ack_up || pkt_active !== 1'b0)
            $display("FAIL post reset join: got ack %b pkt %b expected %b 0", ack_up, pkt_active, m_ack_up);
        else passed++;
    endtask

    task automatic test_sync_latency;
        s_head = 1'b1; s_tail = 1'b1; s_route = 4'b0001; s_req = ~s_req;
        tick(2);
        checks++; if (s_req_dw !== 4'b0000)
            $display("FAIL sync req early: got %b expected 0000", s_req_dw);
        else passed++;
        tick();
        checks++; if (s_req_dw !== 4'b0001)
            $display("FAIL sync req latency: got %b expected 0001", s_req_dw);
        else passed++;
        s_ack_dw ^= 4'b0001;
        tick(3);
        checks++; if (s_ack_up !== 1'b0)
            $display("FAIL sync ack early: got %b expected 0", s_ack_up);
        else passed++;
        tick();
        checks++; if (s_ack_up !== 1'b1 || s_pkt_active !== 1'b0 || s_err !== 1'b0)
            $display("FAIL sync ack latency: got ack %b pkt %b err %b expected 1 0 0", s_ack_up, s_pkt_active, s_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_multi_flit();
        test_single_flit();
        test_idle_errors();
        test_head_in_pkt();
        test_partial_join();
        test_timeout();
        test_random();
        test_async_reset();
        test_sync_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
